// File: rtl/pc_fetch_if.sv
// Fetch unit bus: instruction memory request/response,
// decode hand-off and branch redirect.
interface pc_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        decode_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;

  modport master (
    output imem_req_valid, imem_addr,
    output instr_valid, instr, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  decode_ready, redirect_valid, redirect_target
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    input  instr_valid, instr, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output decode_ready, redirect_valid, redirect_target
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register plus single-entry fetch buffer; one
// outstanding imem request, redirects flush and realign.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  pc_fetch_if.master  bus,
  output logic [31:0] pc,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD,
    DISCARD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        misalign_q, misalign_d;

  assign bus.imem_req_valid = (state_q == FETCH);
  assign bus.imem_addr      = pc_q;
  assign bus.instr_valid    = instr_valid_q;
  assign bus.instr          = instr_q;
  assign bus.instr_pc       = instr_pc_q;
  assign pc                 = pc_q;
  assign misalign_err       = misalign_q;

  // Next state: redirect wins, else the normal fetch cycle
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    misalign_d    = 1'b0;
    if (bus.redirect_valid) begin
      pc_d          = {bus.redirect_target[31:2], 2'b00};
      instr_valid_d = 1'b0;
      misalign_d    = |bus.redirect_target[1:0];
      unique case (state_q)
        FETCH:
          state_d = bus.imem_req_ready ? DISCARD : FETCH;
        WAIT:
          state_d = bus.imem_rsp_valid ? FETCH : DISCARD;
        HOLD:
          state_d = FETCH;
        DISCARD:
          state_d = bus.imem_rsp_valid ? FETCH : DISCARD;
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          if (bus.imem_req_ready) state_d = WAIT;
        end
        WAIT: begin
          if (bus.imem_rsp_valid) begin
            instr_d       = bus.imem_rsp_data;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + 32'd4;
            state_d       = HOLD;
          end
        end
        HOLD: begin
          if (instr_valid_q && bus.decode_ready) begin
            instr_valid_d = 1'b0;
            state_d       = FETCH;
          end
        end
        DISCARD: begin
          if (bus.imem_rsp_valid) state_d = FETCH;
        end
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0;
      instr_pc_q    <= 32'h0;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      misalign_q    <= misalign_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed
// scenarios plus randomized traffic against a model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        misalign_err;

  pc_fetch_if bus ();

  pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .pc           (pc),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Model: outstanding request, whether its reply is
  // to be dropped, and the one-entry decode buffer.
  logic [31:0] m_pc, m_in, m_ipc;
  logic        m_iv, m_mis, m_out, m_disc;

  function automatic logic m_req();
    return !m_out && !m_iv;
  endfunction

  task automatic tick();
    logic rq;
    rq = m_req();
    if (rst) begin
      m_pc = RST_PC; m_in = '0; m_ipc = '0;
      m_iv = 0; m_mis = 0; m_out = 0; m_disc = 0;
    end else if (bus.redirect_valid) begin
      m_pc  = {bus.redirect_target[31:2], 2'b00};
      m_iv  = 0;
      m_mis = (bus.redirect_target[1:0] != 2'b00);
      if (rq && bus.imem_req_ready) begin
        m_out = 1; m_disc = 1;
      end else if (m_out && bus.imem_rsp_valid) begin
        m_out = 0; m_disc = 0;
      end else if (m_out) begin
        m_disc = 1;
      end
    end else begin
      m_mis = 0;
      if (rq && bus.imem_req_ready) begin
        m_out = 1; m_disc = 0;
      end else if (m_out && bus.imem_rsp_valid) begin
        if (!m_disc) begin
          m_in  = bus.imem_rsp_data;
          m_ipc = m_pc;
          m_iv  = 1;
          m_pc  = m_pc + 32'd4;
        end
        m_out = 0; m_disc = 0;
      end else if (m_iv && bus.decode_ready) begin
        m_iv = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.imem_req_ready  = 0;
    bus.imem_rsp_valid  = 0;
    bus.imem_rsp_data   = '0;
    bus.decode_ready    = 0;
    bus.redirect_valid  = 0;
    bus.redirect_target = '0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    reset_dut();
    vectors++;
    if ({pc, bus.instr_valid, bus.instr, bus.instr_pc,
         misalign_err} !== {RST_PC, 1'b0, 64'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state pc=%h iv=%b in=%h ipc=%h mis=%b",
               pc, bus.instr_valid, bus.instr, bus.instr_pc,
               misalign_err);
    end
    vectors++;
    if ({bus.imem_req_valid, bus.imem_addr} !== {1'b1, RST_PC}) begin
      miscompares++;
      $display("FAIL reset_req got %b/%h want 1/%h",
               bus.imem_req_valid, bus.imem_addr, RST_PC);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] w;
    reset_dut();
    bus.imem_req_ready = 1;
    bus.decode_ready   = 1;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if ({bus.imem_req_valid, bus.imem_addr} !== {1'b1, 32'(4 * k)}) begin
        miscompares++;
        $display("FAIL seq_req%0d got %b/%h want 1/%h", k,
                 bus.imem_req_valid, bus.imem_addr, 4 * k);
      end
      tick();
      w = $urandom;
      bus.imem_rsp_valid = 1;
      bus.imem_rsp_data  = w;
      tick();
      bus.imem_rsp_valid = 0;
      vectors++;
      if ({bus.instr_valid, bus.instr, bus.instr_pc, pc} !==
          {1'b1, w, 32'(4 * k), 32'(4 * k + 4)}) begin
        miscompares++;
        $display("FAIL seq_instr%0d got %b/%h/%h pc=%h want 1/%h/%h",
                 k, bus.instr_valid, bus.instr, bus.instr_pc, pc,
                 w, 4 * k);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    logic [31:0] w;
    reset_dut();
    w = $urandom;
    bus.imem_req_ready = 1;
    tick();
    bus.imem_req_ready = 0;
    bus.imem_rsp_valid = 1;
    bus.imem_rsp_data  = w;
    tick();
    bus.imem_rsp_valid = 0;
    bus.imem_rsp_data  = ~w;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({bus.instr_valid, bus.instr, bus.instr_pc,
           bus.imem_req_valid, pc} !==
          {1'b1, w, 32'h0, 1'b0, 32'h4}) begin
        miscompares++;
        $display("FAIL backpressure%0d iv=%b in=%h ipc=%h req=%b pc=%h want 1/%h/0/0/4",
                 i, bus.instr_valid, bus.instr, bus.instr_pc,
                 bus.imem_req_valid, pc, w);
      end
      bus.imem_rsp_valid = (i == 2);
      tick();
    end
    bus.imem_rsp_valid = 0;
    bus.decode_ready = 1;
    tick();
    vectors++;
    if ({bus.instr_valid, bus.imem_req_valid, bus.imem_addr} !==
        {1'b0, 1'b1, 32'h4}) begin
      miscompares++;
      $display("FAIL bp_release iv=%b req=%b addr=%h want 0/1/4",
               bus.instr_valid, bus.imem_req_valid, bus.imem_addr);
    end
    idle_inputs();
  endtask

  task automatic test_redirect_wait();
    logic [31:0] w;
    reset_dut();
    bus.imem_req_ready = 1;
    tick();
    bus.imem_req_ready  = 0;
    bus.redirect_valid  = 1;
    bus.redirect_target = 32'h100;
    tick();
    bus.redirect_valid = 0;
    tick();
    vectors++;
    if ({bus.imem_req_valid, bus.instr_valid, pc} !==
        {1'b0, 1'b0, 32'h100}) begin
      miscompares++;
      $display("FAIL rw_discard req=%b iv=%b pc=%h want 0/0/100",
               bus.imem_req_valid, bus.instr_valid, pc);
    end
    bus.imem_rsp_valid = 1;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    bus.imem_rsp_valid = 0;
    vectors++;
    if ({bus.instr_valid, bus.imem_req_valid, bus.imem_addr} !==
        {1'b0, 1'b1, 32'h100}) begin
      miscompares++;
      $display("FAIL rw_refetch iv=%b req=%b addr=%h want 0/1/100",
               bus.instr_valid, bus.imem_req_valid, bus.imem_addr);
    end
    w = $urandom;
    bus.imem_req_ready = 1;
    tick();
    bus.imem_req_ready = 0;
    vectors++;
    if (bus.instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rw_wait iv=%b want 0", bus.instr_valid);
    end
    bus.imem_rsp_valid = 1;
    bus.imem_rsp_data  = w;
    tick();
    bus.imem_rsp_valid = 0;
    vectors++;
    if ({bus.instr_valid, bus.instr, bus.instr_pc} !==
        {1'b1, w, 32'h100}) begin
      miscompares++;
      $display("FAIL rw_instr got %b/%h/%h want 1/%h/100",
               bus.instr_valid, bus.instr, bus.instr_pc, w);
    end
    idle_inputs();
  endtask

  task automatic test_misalign();
    reset_dut();
    bus.redirect_valid  = 1;
    bus.redirect_target = 32'h203;
    tick();
    bus.redirect_valid = 0;
    vectors++;
    if ({pc, misalign_err} !== {32'h200, 1'b1}) begin
      miscompares++;
      $display("FAIL misalign_hit pc=%h mis=%b want 200/1",
               pc, misalign_err);
    end
    tick();
    vectors++;
    if ({pc, misalign_err} !== {32'h200, 1'b0}) begin
      miscompares++;
      $display("FAIL misalign_pulse pc=%h mis=%b want 200/0",
               pc, misalign_err);
    end
  endtask

  task automatic test_wrap();
    reset_dut();
    bus.redirect_valid  = 1;
    bus.redirect_target = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 0;
    vectors++;
    if ({misalign_err, bus.imem_addr} !== {1'b0, 32'hFFFF_FFFC}) begin
      miscompares++;
      $display("FAIL wrap_redirect mis=%b addr=%h want 0/fffffffc",
               misalign_err, bus.imem_addr);
    end
    bus.imem_req_ready = 1;
    tick();
    bus.imem_req_ready = 0;
    bus.imem_rsp_valid = 1;
    bus.imem_rsp_data  = 32'h0000_0013;
    tick();
    bus.imem_rsp_valid = 0;
    vectors++;
    if ({bus.instr_pc, pc} !== {32'hFFFF_FFFC, 32'h0}) begin
      miscompares++;
      $display("FAIL wrap_pc ipc=%h pc=%h want fffffffc/0",
               bus.instr_pc, pc);
    end
    bus.decode_ready = 1;
    tick();
    vectors++;
    if ({bus.imem_req_valid, bus.imem_addr} !== {1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL wrap_next req=%b addr=%h want 1/0",
               bus.imem_req_valid, bus.imem_addr);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    reset_dut();
    bus.redirect_valid  = 1;
    bus.redirect_target = 32'h40;
    tick();
    bus.redirect_valid = 0;
    bus.imem_req_ready = 1;
    tick();
    bus.imem_req_ready  = 0;
    bus.redirect_valid  = 1;
    bus.redirect_target = 32'h81;
    rst = 1;
    tick();
    rst = 0;
    bus.redirect_valid = 0;
    bus.imem_rsp_valid = 1;
    bus.imem_rsp_data  = 32'hBAD0_BAD0;
    tick();
    bus.imem_rsp_valid = 0;
    vectors++;
    if ({pc, bus.instr_valid, misalign_err, bus.imem_req_valid,
         bus.imem_addr} !== {RST_PC, 1'b0, 1'b0, 1'b1, RST_PC}) begin
      miscompares++;
      $display("FAIL reset_mid pc=%h iv=%b mis=%b req=%b addr=%h",
               pc, bus.instr_valid, misalign_err,
               bus.imem_req_valid, bus.imem_addr);
    end
  endtask

  task automatic test_random();
    logic pend, acc, fired;
    int   cnt;
    reset_dut();
    pend = 0;
    cnt  = 0;
    for (int i = 0; i < 2000; i++) begin
      vectors++;
      if ({bus.imem_req_valid, bus.imem_addr, pc, bus.instr_valid,
           bus.instr, bus.instr_pc, misalign_err} !==
          {m_req(), m_pc, m_pc, m_iv, m_in, m_ipc, m_mis}) begin
        miscompares++;
        $display("FAIL random%0d req=%b pc=%h iv=%b in=%h ipc=%h mis=%b want %b/%h/%b/%h/%h/%b",
                 i, bus.imem_req_valid, pc, bus.instr_valid,
                 bus.instr, bus.instr_pc, misalign_err,
                 m_req(), m_pc, m_iv, m_in, m_ipc, m_mis);
      end
      rst = ($urandom_range(0, 149) == 0);
      bus.redirect_valid  = ($urandom_range(0, 9) == 0);
      bus.redirect_target = $urandom;
      if ($urandom_range(0, 1) == 1)
        bus.redirect_target[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0)
        bus.redirect_target = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      bus.decode_ready   = ($urandom_range(0, 2) != 0);
      bus.imem_req_ready = !pend && ($urandom_range(0, 1) == 1);
      bus.imem_rsp_data  = $urandom;
      if (pend)
        bus.imem_rsp_valid = (cnt == 0);
      else
        bus.imem_rsp_valid = !m_out && ($urandom_range(0, 7) == 0);
      acc   = !rst && m_req() && bus.imem_req_ready;
      fired = pend && bus.imem_rsp_valid;
      tick();
      if (fired) pend = 0;
      else if (pend) cnt--;
      if (acc) begin
        pend = 1;
        cnt  = $urandom_range(0, 2);
      end
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1;
    idle_inputs();
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_misalign();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, meaning the PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 imem_req_valid  output  1  fetch request to instruction memory.
REQ-005 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-006 imem_addr  output  32  fetch address; equals the current pc.
REQ-007 imem_rsp_valid  input  1  instruction word returned this cycle.
REQ-008 imem_rsp_data  input  32  returned instruction word.
REQ-009 instr_valid  output  1  buffered instruction available to decode.
REQ-010 instr  output  32  buffered instruction word.
REQ-011 instr_pc  output  32  address the buffered instruction was fetched from.
REQ-012 decode_ready  input  1  decode consumes the instruction when instr_valid is also 1.
REQ-013 redirect_valid  input  1  branch/jump redirect request.
REQ-014 redirect_target  input  32  redirect destination address.
REQ-015 pc  output  32  current program counter (fetch address register).
REQ-016 misalign_err  output  1  one-cycle pulse when a redirect target has bits [1:0] != 0.

Function
REQ-017 The unit SHALL have four states: FETCH, WAIT, HOLD and DISCARD.
REQ-018 In FETCH, imem_req_valid SHALL be 1 and imem_addr SHALL equal pc; on imem_req_ready=1 the unit SHALL go to WAIT; otherwise it SHALL stay in FETCH with the request held stable.
REQ-019 imem_req_valid SHALL be 0 in WAIT, HOLD and DISCARD.
REQ-020 In WAIT, on imem_rsp_valid=1 the unit SHALL load instr<=imem_rsp_data, instr_pc<=pc, instr_valid<=1 and pc<=pc+4, then go to HOLD.
REQ-021 pc+4 SHALL be a 32-bit modulo add, so 32'hFFFFFFFC increments to 32'h00000000.
REQ-022 In HOLD, when instr_valid=1 and decode_ready=1, the unit SHALL clear instr_valid on the next edge and go to FETCH; otherwise it SHALL hold instr, instr_pc and instr_valid unchanged.
REQ-023 In DISCARD, on imem_rsp_valid=1 the response SHALL be dropped and the unit SHALL go to FETCH; instr and instr_valid SHALL be unaffected.
REQ-024 redirect_valid=1 SHALL have priority over every other event in every state, and SHALL set pc<={redirect_target[31:2],2'b00} and instr_valid<=0 (flushing any buffered instruction).
REQ-025 Next state on a redirect SHALL be:
- FETCH, when in FETCH with imem_req_ready=0;
- DISCARD, when in FETCH with imem_req_ready=1 (the request has been accepted);
- DISCARD, when in WAIT with imem_rsp_valid=0;
- FETCH, when in WAIT with imem_rsp_valid=1 (the response is dropped);
- FETCH, when in HOLD;
- FETCH, when in DISCARD with imem_rsp_valid=1;
- DISCARD, when in DISCARD with imem_rsp_valid=0.
REQ-026 A redirect in HOLD coinciding with decode_ready=1 SHALL count as a completed consume by decode; the buffered instruction is still cleared from the buffer.
REQ-027 misalign_err SHALL be 1 for exactly the cycle after a redirect whose redirect_target[1:0]!=0, and 0 otherwise.
REQ-028 At most one memory request SHALL be outstanding at any time.
REQ-029 imem_rsp_valid received in FETCH or HOLD SHALL be ignored.

Reset
REQ-030 While rst=1 at an edge: pc<=RESET_PC, state<=FETCH, instr_valid<=0, instr<=0, instr_pc<=0, misalign_err<=0.
REQ-031 rst SHALL override redirect_valid and any handshake in the same cycle; a response still outstanding when reset is applied SHALL be ignored.
REQ-032 imem_req_valid SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-033 Sequential fetch: reset, memory always ready, response one cycle after acceptance, decode_ready=1 -> instr_pc sequence 0x0, 0x4, 0x8, with each instruction word delivered unaltered.
REQ-034 Backpressure: decode_ready=0 for 5 cycles after the first instruction arrives -> instr/instr_pc held stable, imem_req_valid=0 throughout, pc=0x4.
REQ-035 Redirect in WAIT: redirect_target=0x100 while WAIT, response arrives 2 cycles later -> that response dropped, next request has imem_addr=0x100, instr_valid stays 0 until the 0x100 word returns.
REQ-036 Misaligned redirect: redirect_target=0x203 -> pc=0x200, misalign_err high for one cycle only.
REQ-037 Wrap-around: redirect to 0xFFFFFFFC, instruction consumed -> pc=0x00000000, next imem_addr=0x0.
REQ-038 Reset mid-fetch: rst asserted while in WAIT, stale response arrives after reset -> pc=RESET_PC, stale response ignored, instr_valid=0, fresh request issued at RESET_PC.
